procyon_retire_trace: RTL and testbench



---
 rtl/procyon_retire_trace_pkg.sv | 29 ++
 rtl/procyon_retire_trace_if.sv | 47 ++++
 rtl/procyon_sync_fifo.sv | 56 +++++
 rtl/procyon_retire_trace.sv | 139 +++++++++++++
 tb/tb_procyon_retire_trace.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/procyon_retire_trace_pkg.sv
// Shared types for the retire/redirect trace capture block.
// PROCYON_RETIRE_TRACE_TIMESTAMP_EN adds a 16-bit cycle stamp to every entry.
package procyon_retire_trace_pkg;

  localparam int TRACE_DATA_WIDTH  = 32;
  localparam int TRACE_RDEST_WIDTH = 5;
  localparam int TRACE_CYCLE_WIDTH = 16;
  localparam int STATE_WIDTH       = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } trace_state_e;

  typedef struct packed {
    logic                         redirect;
    logic [TRACE_RDEST_WIDTH-1:0] rdest;
    logic [TRACE_DATA_WIDTH-1:0]  data;
`ifdef PROCYON_RETIRE_TRACE_TIMESTAMP_EN
    logic [TRACE_CYCLE_WIDTH-1:0] cycle;
`endif
  } trace_entry_t;

  function automatic logic is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/procyon_retire_trace_if.sv
// Core debug outputs into the trace block, and the display/stall signals back out.
// PROCYON_RETIRE_TRACE_TIMESTAMP_EN adds o_disp_cycle.
interface procyon_retire_trace_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int REGMAP_IDX_WIDTH = 5,
  parameter int TRACE_DEPTH      = 8
);

  logic                          i_regmap_retire_en;
  logic [REGMAP_IDX_WIDTH-1:0]   i_regmap_retire_rdest;
  logic [DATA_WIDTH-1:0]         i_regmap_retire_data;
  logic                          i_rob_redirect;
  logic [DATA_WIDTH-1:0]         i_rob_redirect_addr;
  logic                          i_step;

  logic                          o_stall;
  logic                          o_overflow;
  logic [$clog2(TRACE_DEPTH):0]  o_count;
  logic                          o_disp_valid;
  logic                          o_disp_redirect;
  logic [REGMAP_IDX_WIDTH-1:0]   o_disp_rdest;
  logic [DATA_WIDTH-1:0]         o_disp_data;
`ifdef PROCYON_RETIRE_TRACE_TIMESTAMP_EN
  logic [15:0]                   o_disp_cycle;
`endif

  modport master (
`ifdef PROCYON_RETIRE_TRACE_TIMESTAMP_EN
    input  o_disp_cycle,
`endif
    output i_regmap_retire_en, i_regmap_retire_rdest, i_regmap_retire_data,
    output i_rob_redirect, i_rob_redirect_addr, i_step,
    input  o_stall, o_overflow, o_count, o_disp_valid,
    input  o_disp_redirect, o_disp_rdest, o_disp_data
  );

  modport slave (
`ifdef PROCYON_RETIRE_TRACE_TIMESTAMP_EN
    output o_disp_cycle,
`endif
    input  i_regmap_retire_en, i_regmap_retire_rdest, i_regmap_retire_data,
    input  i_rob_redirect, i_rob_redirect_addr, i_step,
    output o_stall, o_overflow, o_count, o_disp_valid,
    output o_disp_redirect, o_disp_rdest, o_disp_data
  );

endinterface

// File: rtl/procyon_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module procyon_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + IDX_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + IDX_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage is left unreset; the pointers and count define which words are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/procyon_retire_trace.sv
// Captures retired register writes and ROB redirects into a trace FIFO and steps them onto the display.
// PROCYON_RETIRE_TRACE_TIMESTAMP_EN stamps each entry with a 16-bit cycle count.
module procyon_retire_trace
  import procyon_retire_trace_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH       = TRACE_DATA_WIDTH,
  parameter int OPTN_REGMAP_IDX_WIDTH = TRACE_RDEST_WIDTH,
  parameter int OPTN_TRACE_DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  procyon_retire_trace_if.slave   bus
);

  localparam int CNT_W   = $clog2(OPTN_TRACE_DEPTH) + 1;
  localparam int ENTRY_W = $bits(trace_entry_t);

  // The entry layout lives in the package, so the widths must agree with it.
  if (OPTN_DATA_WIDTH != TRACE_DATA_WIDTH) begin : g_bad_data_width
    $error("procyon_retire_trace: OPTN_DATA_WIDTH must equal TRACE_DATA_WIDTH");
  end
  if (OPTN_REGMAP_IDX_WIDTH != TRACE_RDEST_WIDTH) begin : g_bad_rdest_width
    $error("procyon_retire_trace: OPTN_REGMAP_IDX_WIDTH must equal TRACE_RDEST_WIDTH");
  end
  if (!is_pow2(OPTN_TRACE_DEPTH) || OPTN_TRACE_DEPTH < 4) begin : g_bad_depth
    $error("procyon_retire_trace: OPTN_TRACE_DEPTH must be a power of two >= 4");
  end

  trace_entry_t                     push_entry;
  trace_entry_t                     head_entry;
  trace_state_e                     state;
  logic                             push_req;
  logic                             push_ok;
  logic                             pop;
  logic                             full;
  logic                             empty;
  logic [CNT_W-1:0]                 count;
  logic [CNT_W-1:0]                 count_next;
  logic                             overflow;
  logic                             disp_valid;
  logic                             disp_redirect;
  logic [OPTN_REGMAP_IDX_WIDTH-1:0] disp_rdest;
  logic [OPTN_DATA_WIDTH-1:0]       disp_data;
`ifdef PROCYON_RETIRE_TRACE_TIMESTAMP_EN
  logic [TRACE_CYCLE_WIDTH-1:0]     cycle_cnt;
  logic [TRACE_CYCLE_WIDTH-1:0]     disp_cycle;
`endif

  // A combined retire+redirect keeps the retire payload and only flags the redirect.
  // NOTE: every field gets a default first so always_comb never holds a value (no latch).
  always_comb begin
    push_entry          = '0;
    push_entry.redirect = bus.i_rob_redirect;
    push_entry.rdest    = bus.i_regmap_retire_en ? bus.i_regmap_retire_rdest : '0;
    push_entry.data     = bus.i_regmap_retire_en ? bus.i_regmap_retire_data
                                                 : bus.i_rob_redirect_addr;
`ifdef PROCYON_RETIRE_TRACE_TIMESTAMP_EN
    push_entry.cycle    = cycle_cnt;
`endif
  end

  assign push_req   = bus.i_regmap_retire_en || bus.i_rob_redirect;
  assign pop        = (state == ST_HOLD) && bus.i_step && !empty;
  assign push_ok    = push_req && (!full || pop);
  assign count_next = count + CNT_W'(push_ok) - CNT_W'(pop);

  procyon_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (OPTN_TRACE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Looking at count_next lets a push into an idle, empty FIFO reach the display two cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      overflow      <= 1'b0;
      disp_valid    <= 1'b0;
      disp_redirect <= 1'b0;
      disp_rdest    <= '0;
      disp_data     <= '0;
`ifdef PROCYON_RETIRE_TRACE_TIMESTAMP_EN
      disp_cycle    <= '0;
`endif
    end else begin
      if (push_req && !push_ok) overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (count_next != '0) state <= ST_LOAD;
        end
        ST_LOAD: begin
          disp_redirect <= head_entry.redirect;
          disp_rdest    <= head_entry.rdest;
          disp_data     <= head_entry.data;
`ifdef PROCYON_RETIRE_TRACE_TIMESTAMP_EN
          disp_cycle    <= head_entry.cycle;
`endif
          disp_valid    <= 1'b1;
          state         <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.i_step) begin
            disp_valid <= 1'b0;
            state      <= (count_next != '0) ? ST_LOAD : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PROCYON_RETIRE_TRACE_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (rst) cycle_cnt <= '0;
    else     cycle_cnt <= cycle_cnt + TRACE_CYCLE_WIDTH'(1);
  end

  assign bus.o_disp_cycle = disp_cycle;
`endif

  // The core sees o_stall a cycle late, so asserting one short of full leaves room for that push.
  assign bus.o_stall         = (count >= CNT_W'(OPTN_TRACE_DEPTH - 1));
  assign bus.o_overflow      = overflow;
  assign bus.o_count         = count;
  assign bus.o_disp_valid    = disp_valid;
  assign bus.o_disp_redirect = disp_redirect;
  assign bus.o_disp_rdest    = disp_rdest;
  assign bus.o_disp_data     = disp_data;

endmodule

// File: tb/tb_procyon_retire_trace.sv
// Directed plus randomized bench for procyon_retire_trace against a queue-based reference model.
// PROCYON_RETIRE_TRACE_TIMESTAMP_EN also checks o_disp_cycle.
module tb_procyon_retire_trace;

  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  procyon_retire_trace_if #(
    .DATA_WIDTH       (DW),
    .REGMAP_IDX_WIDTH (RW),
    .TRACE_DEPTH      (DEPTH)
  ) bus ();

  procyon_retire_trace #(
    .OPTN_DATA_WIDTH       (DW),
    .OPTN_REGMAP_IDX_WIDTH (RW),
    .OPTN_TRACE_DEPTH      (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          redir;
    bit [RW-1:0] rdest;
    bit [DW-1:0] data;
    bit [15:0]   ts;
  } ent_t;

  ent_t      q[$];
  ent_t      m_disp;
  bit        m_valid;
  bit        m_load;
  bit        m_ovf;
  bit [15:0] m_clk;
  int        total;
  int        bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The head reaches the display one blank cycle after it becomes available.
  task automatic model_edge();
    ent_t e;
    bit   want_push;
    bit   do_pop;
    bit   do_push;
    bit   was_load;
    if (rst) begin
      q.delete();
      m_valid = 0;
      m_load  = 0;
      m_ovf   = 0;
      m_disp  = '{default: 0};
      m_clk   = 0;
      return;
    end
    want_push = bus.i_regmap_retire_en || bus.i_rob_redirect;
    e.redir   = bus.i_rob_redirect;
    e.rdest   = bus.i_regmap_retire_en ? bus.i_regmap_retire_rdest : '0;
    e.data    = bus.i_regmap_retire_en ? bus.i_regmap_retire_data : bus.i_rob_redirect_addr;
    e.ts      = m_clk;
    do_pop    = m_valid && bus.i_step;
    do_push   = want_push && (q.size() < DEPTH || do_pop);
    if (want_push && !do_push) m_ovf = 1;
    was_load = m_load;
    if (was_load) begin
      m_disp  = q[0];
      m_valid = 1;
      m_load  = 0;
    end
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(e);
    if (!was_load && (!m_valid || do_pop)) begin
      m_valid = 0;
      m_load  = (q.size() > 0);
    end
    m_clk++;
  endtask

  task automatic check_all(input string tag);
    check({tag, ":count"},    bus.o_count,         64'(q.size()));
    check({tag, ":stall"},    bus.o_stall,         64'(q.size() >= DEPTH - 1));
    check({tag, ":overflow"}, bus.o_overflow,      64'(m_ovf));
    check({tag, ":valid"},    bus.o_disp_valid,    64'(m_valid));
    check({tag, ":redirect"}, bus.o_disp_redirect, 64'(m_disp.redir));
    check({tag, ":rdest"},    bus.o_disp_rdest,    64'(m_disp.rdest));
    check({tag, ":data"},     bus.o_disp_data,     64'(m_disp.data));
`ifdef PROCYON_RETIRE_TRACE_TIMESTAMP_EN
    check({tag, ":cycle"},    bus.o_disp_cycle,    64'(m_disp.ts));
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit en, input bit [RW-1:0] rd, input bit [DW-1:0] d,
                       input bit redir, input bit [DW-1:0] addr, input bit step);
    bus.i_regmap_retire_en    = en;
    bus.i_regmap_retire_rdest = rd;
    bus.i_regmap_retire_data  = d;
    bus.i_rob_redirect        = redir;
    bus.i_rob_redirect_addr   = addr;
    bus.i_step                = step;
  endtask

  task automatic quiet();
    drive(0, '0, '0, 0, '0, 0);
  endtask

  task automatic wait_shown(input string tag);
    int n = 0;
    quiet();
    while (!bus.o_disp_valid && n < 20) begin
      tick(tag);
      n++;
    end
    check({tag, ":shown_in_time"}, bus.o_disp_valid, 64'(1));
  endtask

  task automatic step_once(input string tag);
    drive(0, '0, '0, 0, '0, 1);
    tick(tag);
    quiet();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    quiet();

    // Reset, then a step while idle must do nothing.
    rst = 1;
    tick("rst0");
    tick("rst1");
    rst = 0;
    tick("idle0");
    step_once("step_idle");
    tick("idle1");

    // Single retire: visible two cycles after the push, gone one cycle after the step.
    drive(1, 5'd5, 32'hDEADBEEF, 0, '0, 0);
    tick("t2_push");
    quiet();
    tick("t2_load");
    check("t2_valid", bus.o_disp_valid, 64'(1));
    check("t2_rdest", bus.o_disp_rdest, 64'(5));
    check("t2_data",  bus.o_disp_data,  64'(32'hDEADBEEF));
    check("t2_count", bus.o_count,      64'(1));
    tick("t2_hold");
    step_once("t2_step");
    check("t2_valid_drop", bus.o_disp_valid, 64'(0));
    check("t2_count_drop", bus.o_count,      64'(0));
    check("t2_data_keep",  bus.o_disp_data,  64'(32'hDEADBEEF));

    // Back-to-back retires past full: the ninth is dropped and overflow sticks.
    for (int i = 0; i < 9; i++) begin
      drive(1, RW'(i + 1), 32'h1000 + i, 0, '0, 0);
      tick("t3_fill");
      if (i == 6) check("t3_stall7", bus.o_stall, 64'(1));
    end
    quiet();
    check("t3_overflow", bus.o_overflow, 64'(1));
    check("t3_count8",   bus.o_count,    64'(8));
    for (int i = 0; i < 8; i++) begin
      wait_shown("t3_drain_wait");
      step_once("t3_drain");
    end
    tick("t3_after");
    check("t3_ovf_sticky", bus.o_overflow, 64'(1));
    check("t3_empty",      bus.o_count,    64'(0));

    rst = 1;
    tick("rst2");
    rst = 0;

    // Redirect alone, then retire and redirect together.
    drive(0, 5'd7, '0, 1, 32'h100, 0);
    tick("t4_redir");
    wait_shown("t4_wait1");
    check("t4_r_redirect", bus.o_disp_redirect, 64'(1));
    check("t4_r_rdest",    bus.o_disp_rdest,    64'(0));
    check("t4_r_data",     bus.o_disp_data,     64'(32'h100));
    step_once("t4_step1");
    drive(1, 5'd3, 32'h42, 1, 32'h200, 0);
    tick("t4_both");
    wait_shown("t4_wait2");
    check("t4_b_redirect", bus.o_disp_redirect, 64'(1));
    check("t4_b_rdest",    bus.o_disp_rdest,    64'(3));
    check("t4_b_data",     bus.o_disp_data,     64'(32'h42));
    step_once("t4_step2");

    // Full FIFO: a step with a same-cycle retire keeps count at full without overflow.
    for (int i = 0; i < 8; i++) begin
      drive(1, RW'(i), 32'h2000 + i, 0, '0, 0);
      tick("t5_fill");
    end
    wait_shown("t5_wait");
    drive(1, 5'd9, 32'h2FFF, 0, '0, 1);
    tick("t5_swap");
    quiet();
    check("t5_count",    bus.o_count,    64'(8));
    check("t5_overflow", bus.o_overflow, 64'(0));
    wait_shown("t5_wait2");
    check("t5_next", bus.o_disp_data, 64'(32'h2001));

    // Drain to three entries, then reset in the middle of HOLD.
    for (int i = 0; i < 5; i++) begin
      step_once("t6_drain");
      wait_shown("t6_wait");
    end
    check("t6_count3", bus.o_count, 64'(3));
    rst = 1;
    tick("t6_rst");
    check("t6_count0", bus.o_count,      64'(0));
    check("t6_valid0", bus.o_disp_valid, 64'(0));
    check("t6_ovf0",   bus.o_overflow,   64'(0));
    check("t6_data0",  bus.o_disp_data,  64'(0));
    rst = 0;
    drive(1, 5'd1, 32'hC0FFEE, 0, '0, 0);
    tick("t6_first_push");
    wait_shown("t6_wait_ts");
`ifdef PROCYON_RETIRE_TRACE_TIMESTAMP_EN
    check("t6_cycle0", bus.o_disp_cycle, 64'(0));
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 1) == 1, RW'($urandom), $urandom,
            $urandom_range(0, 4) == 0, $urandom, $urandom_range(0, 2) == 0);
      tick("rand");
    end
    rst = 0;
    quiet();
    tick("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
